// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline stage blocks and the hazard sequencer.
// master = stage side (supplies register fields and memory status),
// slave  = hazard_ctrl (returns stall/flush/forward controls and status).
//
// Data-memory handshake: dmem_req stays high while the mem stage holds an
// outstanding access. dmem_ready is high in the single cycle the memory
// completes it. A cycle with dmem_req=1 and dmem_ready=0 is a wait cycle.
// A cycle with both high completes the access without waiting.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   // decode stage
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   // execute stage
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic [1:0]       ex_result_src;
   logic             ex_regfile_wr_enable;
   logic             ex_pc_src;
   // mem stage
   logic [4:0]       mem_rd;
   logic             mem_regfile_wr_enable;
   // writeback stage
   logic [4:0]       wb_rd;
   logic             wb_regfile_wr_enable;
   // data memory status
   logic             dmem_req;
   logic             dmem_ready;
   // controls back to the stages
   logic             stall_fetch;
   logic             stall_decode;
   logic             stall_execute;
   logic             stall_mem;
   logic             flush_fetch;
   logic             flush_decode;
   logic             flush_mem;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   // status and observability
   logic             mem_fault;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] redirect_count;
   logic             mem_wait_state;   // 1 while the FSM is in MEM_WAIT

   modport master (
      output id_rs1, id_rs2,
      output ex_rs1, ex_rs2, ex_rd, ex_result_src, ex_regfile_wr_enable, ex_pc_src,
      output mem_rd, mem_regfile_wr_enable,
      output wb_rd, wb_regfile_wr_enable,
      output dmem_req, dmem_ready,
      input  stall_fetch, stall_decode, stall_execute, stall_mem,
      input  flush_fetch, flush_decode, flush_mem,
      input  forward_a, forward_b,
      input  mem_fault, stall_cycles, redirect_count, mem_wait_state
   );

   modport slave (
      input  id_rs1, id_rs2,
      input  ex_rs1, ex_rs2, ex_rd, ex_result_src, ex_regfile_wr_enable, ex_pc_src,
      input  mem_rd, mem_regfile_wr_enable,
      input  wb_rd, wb_regfile_wr_enable,
      input  dmem_req, dmem_ready,
      output stall_fetch, stall_decode, stall_execute, stall_mem,
      output flush_fetch, flush_decode, flush_mem,
      output forward_a, forward_b,
      output mem_fault, stall_cycles, redirect_count, mem_wait_state
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline.
// Produces per-stage stall/flush controls and execute-stage forwarding
// selects. A two-state FSM freezes the whole pipeline while a data access
// waits and aborts the access after MEM_TIMEOUT stalled cycles, raising a
// sticky mem_fault. Stall cycles and accepted redirects are counted with
// saturating counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic          clk,
   input logic          rstn,
   hazard_ctrl_if.slave hz
);

   localparam int               WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;

   // hazard conditions seen this cycle
   logic memwait;
   logic redirect;
   logic loaduse;

   // raw controls before the reset gate
   logic       stall_front;     // fetch + decode
   logic       stall_back;      // execute + mem
   logic       fl_fetch;
   logic       fl_decode;
   logic       fl_mem;
   logic       fault_set;
   logic       redirect_taken;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   logic             fault_q;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   // Operand source for one execute operand: mem result wins over wb,
   // and x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] m_rd,
      input logic       m_we,
      input logic [4:0] w_rd,
      input logic       w_we
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
         sel = 2'b10;
      end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Hazard detection from the current stage contents.
   always_comb begin
      memwait  = hz.dmem_req && !hz.dmem_ready;
      redirect = hz.ex_pc_src;
      loaduse  = (hz.ex_result_src == 2'b01) && hz.ex_regfile_wr_enable &&
                 (hz.ex_rd != 5'd0) &&
                 ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
   end

   // Forwarding selects, independent of the FSM state.
   always_comb begin
      fwd_a = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_regfile_wr_enable,
                      hz.wb_rd, hz.wb_regfile_wr_enable);
      fwd_b = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_regfile_wr_enable,
                      hz.wb_rd, hz.wb_regfile_wr_enable);
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next state, wait counter and pipeline controls.
   // In RUN the priority is memwait > redirect > loaduse. While the pipeline
   // is frozen in MEM_WAIT, redirect and loaduse are ignored: execute does
   // not advance, so they are evaluated again after the access ends.
   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      stall_front    = 1'b0;
      stall_back     = 1'b0;
      fl_fetch       = 1'b0;
      fl_decode      = 1'b0;
      fl_mem         = 1'b0;
      fault_set      = 1'b0;
      redirect_taken = 1'b0;
      case (state)
         RUN: begin
            if (memwait) begin
               stall_front  = 1'b1;
               stall_back   = 1'b1;
               fl_mem       = 1'b1;
               wait_cnt_nxt = WAIT_ONE;
               state_nxt    = MEM_WAIT;
            end else if (redirect) begin
               // decode holds a wrong-path instruction, so loaduse is moot
               fl_fetch       = 1'b1;
               fl_decode      = 1'b1;
               redirect_taken = 1'b1;
            end else if (loaduse) begin
               // one bubble; the load then sits in mem and forwards
               stall_front = 1'b1;
               fl_decode   = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (hz.dmem_ready) begin
               wait_cnt_nxt = '0;
               state_nxt    = RUN;
            end else if (wait_cnt == WAIT_LIMIT) begin
               // abort: release the pipeline and drop the access result
               fl_mem       = 1'b1;
               fault_set    = 1'b1;
               wait_cnt_nxt = '0;
               state_nxt    = RUN;
            end else begin
               stall_front  = 1'b1;
               stall_back   = 1'b1;
               fl_mem       = 1'b1;
               wait_cnt_nxt = wait_cnt + WAIT_ONE;
            end
         end
         default: begin
            wait_cnt_nxt = '0;
            state_nxt    = RUN;
         end
      endcase
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fault_q <= 1'b0;
      end else if (fault_set) begin
         fault_q <= 1'b1;
      end
   end

   // Saturating count of cycles with stall_fetch asserted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (stall_front && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   // Saturating count of accepted redirects.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         redirect_cnt <= '0;
      end else if (redirect_taken && (redirect_cnt != CNT_MAX)) begin
         redirect_cnt <= redirect_cnt + CNT_ONE;
      end
   end

   // Outputs: controls are forced quiet while reset is held, without
   // waiting for a clock edge.
   always_comb begin
      hz.stall_fetch    = rstn & stall_front;
      hz.stall_decode   = rstn & stall_front;
      hz.stall_execute  = rstn & stall_back;
      hz.stall_mem      = rstn & stall_back;
      hz.flush_fetch    = rstn & fl_fetch;
      hz.flush_decode   = rstn & fl_decode;
      hz.flush_mem      = rstn & fl_mem;
      hz.forward_a      = rstn ? fwd_a : 2'b00;
      hz.forward_b      = rstn ? fwd_b : 2'b00;
      hz.mem_fault      = fault_q;
      hz.stall_cycles   = stall_cnt;
      hz.redirect_count = redirect_cnt;
      hz.mem_wait_state = (state == MEM_WAIT);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4).
module tb_hazard_ctrl;

   localparam int MT   = 8;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // expected counters (unsaturated) and access state of the model
   int   exp_stalls = 0;
   int   exp_redirs = 0;
   bit   exp_fault  = 1'b0;
   int   exp_age    = 0;     // stalled cycles of the current access, 0 = none
   int   nxt_age    = 0;
   bit   nxt_fault  = 1'b0;

   logic [10:0] exp_q[$];

   hazard_ctrl_if #(.CNT_W(CW)) bus ();

   hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .hz   (bus)
   );

   // clock
   always #5 clk = ~clk;

   // {stall_fetch, stall_decode, stall_execute, stall_mem, flush_fetch, flush_decode, flush_mem}
   logic [6:0] ctrl;
   assign ctrl = {bus.stall_fetch, bus.stall_decode, bus.stall_execute, bus.stall_mem,
                  bus.flush_fetch, bus.flush_decode, bus.flush_mem};

   localparam logic [6:0] C_NONE  = 7'b0000000;
   localparam logic [6:0] C_FREEZ = 7'b1111001;
   localparam logic [6:0] C_LU    = 7'b1100010;
   localparam logic [6:0] C_REDIR = 7'b0000110;
   localparam logic [6:0] C_ABORT = 7'b0000001;

   // load-use table: ex_result_src, ex_we, ex_rd, id_rs1, id_rs2, stall expected
   logic [1:0] lu_src [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11};
   logic       lu_we  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [4:0] lu_rd  [6] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd0, 5'd5};
   logic [4:0] lu_id1 [6] = '{5'd9, 5'd5, 5'd5, 5'd5, 5'd0, 5'd5};
   logic [4:0] lu_id2 [6] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5};
   logic       lu_hit [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.id_rs1 = '0; bus.id_rs2 = '0;
      bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0;
      bus.ex_result_src = '0; bus.ex_regfile_wr_enable = 1'b0; bus.ex_pc_src = 1'b0;
      bus.mem_rd = '0; bus.mem_regfile_wr_enable = 1'b0;
      bus.wb_rd = '0; bus.wb_regfile_wr_enable = 1'b0;
      bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_load(input logic [1:0] src, input logic we, input logic [4:0] rd,
                             input logic [4:0] id1, input logic [4:0] id2);
      bus.ex_result_src = src;
      bus.ex_regfile_wr_enable = we;
      bus.ex_rd = rd;
      bus.id_rs1 = id1;
      bus.id_rs2 = id2;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (bus.mem_regfile_wr_enable && bus.mem_rd != 0 && bus.mem_rd == rs) return 2'b10;
      if (bus.wb_regfile_wr_enable && bus.wb_rd != 0 && bus.wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Predicts this cycle's controls from the rules and the access age;
   // counters and next age are applied by the caller after the edge.
   task automatic model_predict(output logic [10:0] v);
      logic [6:0] c;
      bit waiting, lu;
      c = C_NONE;
      nxt_age = exp_age;
      nxt_fault = exp_fault;
      waiting = bus.dmem_req && !bus.dmem_ready;
      lu = (bus.ex_result_src == 2'b01) && bus.ex_regfile_wr_enable && bus.ex_rd != 0 &&
           (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
      if (exp_age == 0) begin
         if (waiting) begin
            c = C_FREEZ; nxt_age = 1;
         end else if (bus.ex_pc_src) begin
            c = C_REDIR; exp_redirs = exp_redirs + 1;
         end else if (lu) begin
            c = C_LU;
         end
      end else if (bus.dmem_ready) begin
         nxt_age = 0;
      end else if (exp_age >= MT) begin
         c = C_ABORT; nxt_fault = 1'b1; nxt_age = 0;
      end else begin
         c = C_FREEZ; nxt_age = exp_age + 1;
      end
      if (c[6]) exp_stalls = exp_stalls + 1;
      v = {c, ref_fwd(bus.ex_rs1), ref_fwd(bus.ex_rs2)};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      bus.ex_rs1 = 5'd3; bus.mem_rd = 5'd3; bus.mem_regfile_wr_enable = 1'b1;
      bus.ex_rs2 = 5'd4; bus.wb_rd = 5'd4; bus.wb_regfile_wr_enable = 1'b1;
      bus.dmem_req = 1'b1; bus.ex_pc_src = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ctrl !== C_NONE) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_NONE); end
         checks++;
         if ({bus.forward_a, bus.forward_b} !== 4'b0000) begin errors++;
            $display("FAIL reset_fwd got=%b%b exp=0000", bus.forward_a, bus.forward_b); end
         checks++;
         if ({bus.mem_fault, bus.mem_wait_state, bus.stall_cycles, bus.redirect_count} !== 10'd0) begin errors++;
            $display("FAIL reset_state fault=%b wait=%b stalls=%0d redirs=%0d exp all 0",
                     bus.mem_fault, bus.mem_wait_state, bus.stall_cycles, bus.redirect_count); end
         step();
      end
      clear_inputs();
      rstn = 1'b1;
      exp_stalls = 0; exp_redirs = 0; exp_fault = 1'b0; exp_age = 0;
      step();
   endtask

   task automatic test_redirect();
      clear_inputs();
      drive_load(2'b01, 1'b1, 5'd5, 5'd5, 5'd0);
      bus.ex_pc_src = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_REDIR) begin errors++; $display("FAIL redirect_ctrl got=%b exp=%b", ctrl, C_REDIR); end
      step();
      exp_redirs++;
      checks++;
      if (bus.redirect_count !== CW'(sat(exp_redirs))) begin errors++;
         $display("FAIL redirect_count got=%0d exp=%0d", bus.redirect_count, sat(exp_redirs)); end
      checks++;
      if (bus.stall_cycles !== CW'(sat(exp_stalls))) begin errors++;
         $display("FAIL redirect_stalls got=%0d exp=%0d", bus.stall_cycles, sat(exp_stalls)); end
      clear_inputs();
   endtask

   task automatic test_loaduse();
      for (int k = 0; k < 6; k++) begin
         clear_inputs();
         drive_load(lu_src[k], lu_we[k], lu_rd[k], lu_id1[k], lu_id2[k]);
         #1;
         checks++;
         if (ctrl !== (lu_hit[k] ? C_LU : C_NONE)) begin errors++;
            $display("FAIL loaduse_ctrl case=%0d got=%b exp=%b", k, ctrl, lu_hit[k] ? C_LU : C_NONE); end
         step();
         if (lu_hit[k]) exp_stalls++;
      end
      // dependent instruction now in execute, load in mem
      clear_inputs();
      drive_load(2'b01, 1'b1, 5'd5, 5'd9, 5'd5);
      step();
      exp_stalls++;
      clear_inputs();
      bus.ex_rd = 5'd6; bus.ex_rs1 = 5'd9; bus.ex_rs2 = 5'd5;
      bus.mem_rd = 5'd5; bus.mem_regfile_wr_enable = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_NONE) begin errors++; $display("FAIL loaduse_release got=%b exp=%b", ctrl, C_NONE); end
      checks++;
      if ({bus.forward_a, bus.forward_b} !== 4'b0010) begin errors++;
         $display("FAIL loaduse_forward got=%b%b exp=0010", bus.forward_a, bus.forward_b); end
      checks++;
      if (bus.stall_cycles !== CW'(sat(exp_stalls))) begin errors++;
         $display("FAIL loaduse_stalls got=%0d exp=%0d", bus.stall_cycles, sat(exp_stalls)); end
      step();
      clear_inputs();
   endtask

   task automatic test_forwarding();
      logic [3:0] exp_f;
      for (int k = 0; k < 5; k++) begin
         clear_inputs();
         case (k)
            0: begin bus.mem_rd = 5'd7; bus.mem_regfile_wr_enable = 1'b1; bus.wb_rd = 5'd7;
                     bus.wb_regfile_wr_enable = 1'b1; bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7; exp_f = 4'b1010; end
            1: begin bus.mem_rd = 5'd7; bus.wb_rd = 5'd7;
                     bus.wb_regfile_wr_enable = 1'b1; bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7; exp_f = 4'b0101; end
            2: begin bus.mem_rd = 5'd7; bus.wb_rd = 5'd7; bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7; exp_f = 4'b0000; end
            3: begin bus.mem_regfile_wr_enable = 1'b1; bus.wb_regfile_wr_enable = 1'b1; exp_f = 4'b0000; end
            default: begin bus.mem_rd = 5'd3; bus.mem_regfile_wr_enable = 1'b1; bus.wb_rd = 5'd4;
                     bus.wb_regfile_wr_enable = 1'b1; bus.ex_rs1 = 5'd4; bus.ex_rs2 = 5'd3; exp_f = 4'b0110; end
         endcase
         #1;
         checks++;
         if ({bus.forward_a, bus.forward_b} !== exp_f) begin errors++;
            $display("FAIL forward case=%0d got=%b%b exp=%b", k, bus.forward_a, bus.forward_b, exp_f); end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      clear_inputs();
      bus.dmem_req = 1'b1; bus.ex_pc_src = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         #1;
         checks++;
         if (ctrl !== C_FREEZ) begin errors++; $display("FAIL memwait_ctrl c=%0d got=%b exp=%b", c, ctrl, C_FREEZ); end
         checks++;
         if (bus.mem_wait_state !== ((c > 1) ? 1'b1 : 1'b0)) begin errors++;
            $display("FAIL memwait_state c=%0d got=%b", c, bus.mem_wait_state); end
         step();
         exp_stalls++;
      end
      bus.dmem_ready = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_NONE) begin errors++; $display("FAIL memwait_ready got=%b exp=%b", ctrl, C_NONE); end
      step();
      bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_wait_state !== 1'b0) begin errors++; $display("FAIL memwait_back_to_run got=%b exp=0", bus.mem_wait_state); end
      checks++;
      if (ctrl !== C_REDIR) begin errors++; $display("FAIL deferred_redirect got=%b exp=%b", ctrl, C_REDIR); end
      checks++;
      if ({bus.stall_cycles, bus.redirect_count} !== {CW'(sat(exp_stalls)), CW'(sat(exp_redirs))}) begin errors++;
         $display("FAIL memwait_counters stalls=%0d redirs=%0d exp %0d %0d",
                  bus.stall_cycles, bus.redirect_count, sat(exp_stalls), sat(exp_redirs)); end
      step();
      exp_redirs++;
      clear_inputs();
   endtask

   task automatic test_timeout();
      clear_inputs();
      bus.dmem_req = 1'b1;
      for (int c = 1; c <= MT; c++) begin
         #1;
         checks++;
         if ({ctrl, bus.mem_fault} !== {C_FREEZ, 1'b0}) begin errors++;
            $display("FAIL timeout_wait c=%0d got=%b fault=%b exp=%b fault=0", c, ctrl, bus.mem_fault, C_FREEZ); end
         step();
         exp_stalls++;
      end
      #1;
      checks++;
      if ({ctrl, bus.mem_fault} !== {C_ABORT, 1'b0}) begin errors++;
         $display("FAIL timeout_abort got=%b fault=%b exp=%b fault=0", ctrl, bus.mem_fault, C_ABORT); end
      step();
      #1;
      checks++;
      if (bus.mem_fault !== 1'b1) begin errors++; $display("FAIL timeout_fault got=%b exp=1", bus.mem_fault); end
      checks++;
      if (ctrl !== C_FREEZ) begin errors++; $display("FAIL timeout_new_access got=%b exp=%b", ctrl, C_FREEZ); end
      step();
      exp_stalls++;
      bus.dmem_ready = 1'b1;
      step();
      clear_inputs();
      #1;
      checks++;
      if ({bus.mem_fault, bus.stall_cycles} !== {1'b1, CW'(sat(exp_stalls))}) begin errors++;
         $display("FAIL timeout_sticky fault=%b stalls=%0d exp fault=1 stalls=%0d",
                  bus.mem_fault, bus.stall_cycles, sat(exp_stalls)); end
      step();
   endtask

   task automatic test_async_reset_saturation();
      clear_inputs();
      bus.dmem_req = 1'b1;
      step();
      bus.mem_rd = 5'd2; bus.mem_regfile_wr_enable = 1'b1; bus.ex_rs1 = 5'd2; bus.ex_rs2 = 5'd2;
      #1;
      checks++;
      if (ctrl !== C_FREEZ) begin errors++; $display("FAIL prereset_ctrl got=%b exp=%b", ctrl, C_FREEZ); end
      rstn = 1'b0;
      #1;
      checks++;
      if ({ctrl, bus.forward_a, bus.forward_b} !== 11'd0) begin errors++;
         $display("FAIL async_reset_ctrl got=%b fwd=%b%b exp all 0", ctrl, bus.forward_a, bus.forward_b); end
      checks++;
      if ({bus.mem_fault, bus.mem_wait_state, bus.stall_cycles, bus.redirect_count} !== 10'd0) begin errors++;
         $display("FAIL async_reset_state fault=%b wait=%b stalls=%0d redirs=%0d exp all 0",
                  bus.mem_fault, bus.mem_wait_state, bus.stall_cycles, bus.redirect_count); end
      #1;
      clear_inputs();
      rstn = 1'b1;
      exp_stalls = 0; exp_redirs = 0; exp_fault = 1'b0; exp_age = 0;
      step();
      drive_load(2'b01, 1'b1, 5'd8, 5'd8, 5'd1);
      for (int n = 1; n <= 20; n++) begin
         step();
         exp_stalls++;
         checks++;
         if (bus.stall_cycles !== CW'(sat(exp_stalls))) begin errors++;
            $display("FAIL saturate n=%0d got=%0d exp=%0d", n, bus.stall_cycles, sat(exp_stalls)); end
      end
      clear_inputs();
      step();
   endtask

   task automatic test_random();
      logic [10:0] exp_v;
      logic [10:0] got_v;
      int ready_pct;
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      exp_stalls = 0; exp_redirs = 0; exp_fault = 1'b0; exp_age = 0;
      exp_q.delete();
      for (int blk = 0; blk < 3; blk++) begin
         ready_pct = (blk == 0) ? 60 : ((blk == 1) ? 20 : 0);
         for (int n = 0; n < 150; n++) begin
            bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
            bus.ex_rs1 = 5'($urandom_range(0, 3)); bus.ex_rs2 = 5'($urandom_range(0, 3));
            bus.ex_rd  = 5'($urandom_range(0, 3));
            bus.ex_result_src = 2'($urandom_range(0, 3));
            bus.ex_regfile_wr_enable = 1'($urandom_range(0, 1));
            bus.ex_pc_src = ($urandom_range(0, 99) < 20);
            bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_regfile_wr_enable = 1'($urandom_range(0, 1));
            bus.wb_rd  = 5'($urandom_range(0, 3)); bus.wb_regfile_wr_enable  = 1'($urandom_range(0, 1));
            bus.dmem_req = ($urandom_range(0, 99) < 30);
            bus.dmem_ready = ($urandom_range(0, 99) < ready_pct);
            model_predict(exp_v);
            exp_q.push_back(exp_v);
            #1;
            got_v = {ctrl, bus.forward_a, bus.forward_b};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin errors++;
               $display("FAIL random_ctrl blk=%0d n=%0d got=%b exp=%b", blk, n, got_v, exp_v); end
            checks++;
            if (bus.mem_wait_state !== ((exp_age > 0) ? 1'b1 : 1'b0)) begin errors++;
               $display("FAIL random_state blk=%0d n=%0d got=%b age=%0d", blk, n, bus.mem_wait_state, exp_age); end
            step();
            exp_age = nxt_age;
            exp_fault = nxt_fault;
            checks++;
            if ({bus.mem_fault, bus.stall_cycles, bus.redirect_count} !==
                {exp_fault, CW'(sat(exp_stalls)), CW'(sat(exp_redirs))}) begin errors++;
               $display("FAIL random_regs blk=%0d n=%0d fault=%b stalls=%0d redirs=%0d exp %b %0d %0d",
                        blk, n, bus.mem_fault, bus.stall_cycles, bus.redirect_count,
                        exp_fault, sat(exp_stalls), sat(exp_redirs)); end
         end
      end
      clear_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_redirect();
      test_loaduse();
      test_forwarding();
      test_mem_wait();
      test_timeout();
      test_async_reset_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage RV32I core: fetch, decode, execute, mem, writeback. It generates per-stage stall and flush controls and the execute-stage operand forwarding selects. It runs a small FSM that freezes the pipeline while a data-memory access waits, and aborts that access on timeout. It also keeps saturating stall and redirect counters. It sits beside the stage blocks; its flush_decode drives the decode stage's existing synchronous flush (bubble into execute).

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles a memory access may stall before abort (>=2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rstn  in  1  reset, asynchronous, active-low
id_rs1  in  5  rs1 field of the instruction currently in decode
id_rs2  in  5  rs2 field of the instruction currently in decode
ex_rs1  in  5  rs1 of the instruction in execute (decode_rs1)
ex_rs2  in  5  rs2 of the instruction in execute (decode_rs2)
ex_rd  in  5  rd of the instruction in execute
ex_result_src  in  2  result source in execute; 01 = load
ex_regfile_wr_enable  in  1  execute instruction writes rd
ex_pc_src  in  1  taken branch/jump resolved in execute
mem_rd  in  5  rd in mem stage
mem_regfile_wr_enable  in  1  mem-stage instruction writes rd
wb_rd  in  5  rd in writeback
wb_regfile_wr_enable  in  1  writeback instruction writes rd
dmem_req  in  1  mem stage has an outstanding data access
dmem_ready  in  1  data memory completes the access this cycle
stall_fetch  out  1  hold PC
stall_decode  out  1  hold fetch/decode register
stall_execute  out  1  hold decode/execute register
stall_mem  out  1  hold execute/mem register
flush_fetch  out  1  kill instruction entering decode
flush_decode  out  1  insert bubble into execute
flush_mem  out  1  insert bubble into writeback
forward_a  out  2  execute operand A select: 00 regfile, 01 wb, 10 mem
forward_b  out  2  same for operand B
mem_fault  out  1  sticky: a memory access timed out
stall_cycles  out  CNT_W  saturating count of cycles with stall_fetch=1
redirect_count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (rstn=0, async): state=RUN, wait_cnt=0, mem_fault=0, both counters 0. While rstn=0, all stall/flush outputs are 0 and forward_a/b are 00.
- Forwarding (combinational, all states):
  - forward_a=10 if mem_regfile_wr_enable && mem_rd!=0 && mem_rd==ex_rs1.
  - Else forward_a=01 if wb_regfile_wr_enable && wb_rd!=0 && wb_rd==ex_rs1.
  - Else forward_a=00. forward_b is identical using ex_rs2. Mem has priority over wb.
- Signals:
  - memwait = dmem_req && !dmem_ready.
  - redirect = ex_pc_src.
  - loaduse = ex_result_src==01 && ex_regfile_wr_enable && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- FSM states: RUN, MEM_WAIT. wait_cnt is a counter of ceil(log2(MEM_TIMEOUT+1)) bits.
- RUN, priority memwait > redirect > loaduse:
  - memwait: stall_fetch/decode/execute/mem=1, flush_mem=1, wait_cnt<=1, next MEM_WAIT. Redirect and loaduse are ignored; ex is frozen, so they re-evaluate later.
  - redirect: flush_fetch=1, flush_decode=1, no stalls, redirect_count++. Loaduse is suppressed because the decode instruction is wrong-path.
  - loaduse: stall_fetch=1, stall_decode=1, flush_decode=1, lasting exactly 1 cycle. Next cycle the load is in mem and forwarding resolves the dependency.
  - Otherwise: all controls 0.
- MEM_WAIT:
  - dmem_ready=1: stalls and flush_mem=0 this cycle, wait_cnt<=0, next RUN.
  - Else if wait_cnt==MEM_TIMEOUT: abort. Stalls=0, flush_mem=1, mem_fault<=1, wait_cnt<=0, next RUN. Total stalled cycles = MEM_TIMEOUT.
  - Else: all four stalls=1, flush_mem=1, wait_cnt++.
- After an abort, the first RUN cycle treats dmem_req as a new access.
- mem_fault clears only on reset.
- Counters: stall_cycles increments on every cycle with stall_fetch=1; redirect_count increments per accepted redirect. Both hold at 2^CNT_W-1.

Test Plan:
- Load x5 in ex (ex_result_src=01, ex_rd=5), id_rs2=5 -> one cycle stall_fetch=stall_decode=flush_decode=1, then 0; next cycle mem_rd=5 with ex_rs2=5 gives forward_b=10.
- ex_rd=0 load with id_rs1=0 -> no stall. mem_rd=wb_rd=7, ex_rs1=7 -> forward_a=10. Drop mem_regfile_wr_enable -> forward_a=01.
- ex_pc_src=1 together with loaduse -> flush_fetch=flush_decode=1, stall_fetch=0, redirect_count 0->1.
- dmem_req=1, dmem_ready low for 3 cycles then high -> stalls/flush_mem=1 for exactly 3 cycles, 0 on the ready cycle, state back to RUN, stall_cycles=3. A simultaneous ex_pc_src is deferred until after the wait.
- MEM_TIMEOUT=8, dmem_ready never -> stalls high 8 cycles, then cycle 9 stalls=0, flush_mem=1, mem_fault=1 from cycle 10 and sticky.
- Assert rstn=0 mid-MEM_WAIT -> outputs 0 immediately (async), counters and mem_fault 0. CNT_W=4, 20 stall cycles -> stall_cycles saturates at 15.
